pwm_dac: RTL

Output stage directly downstream of the NCO. It consumes the NCO's 8-bit sample stream (`data_o`) and applies a programmable gain with saturation. It converts the scaled sample to a single-bit PWM waveform for an external RC filter / pin. The sample is captured once per PWM period, so duty changes never glitch mid-period.

---
 rtl/wavegen_pkg.sv | 18 +
 rtl/gain_sat.sv | 17 +
 rtl/pwm_dac.sv | 102 ++++++++++
 3 files changed

// File: rtl/wavegen_pkg.sv
// Shared types and constants for the waveform output path (NCO -> PWM DAC).
package wavegen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } pwm_state_t;

  localparam logic [7:0] GAIN_UNITY = 8'd128;
  localparam int         SAMPLE_W   = 8;

  // Clamp a 9-bit scaled value into the 8-bit sample range.
  function automatic logic [7:0] sat8(input logic [8:0] v);
    return v[8] ? 8'hFF : v[7:0];
  endfunction

endpackage

// File: rtl/gain_sat.sv
// Combinational Q1.7 gain stage: sample * gain >> 7, saturated to 8 bits.
module gain_sat
  import wavegen_pkg::*;
(
  input  logic [SAMPLE_W-1:0] sample,
  input  logic [7:0]          gain,
  output logic [SAMPLE_W-1:0] scaled
);

  logic [15:0] prod;
  logic [8:0]  shifted;

  assign prod    = 16'(sample) * 16'(gain);
  assign shifted = prod[15:7];
  assign scaled  = sat8(shifted);

endmodule

// File: rtl/pwm_dac.sv
// PWM DAC: scales each NCO sample by a shadowed gain and emits a glitch-free
// single-bit PWM whose duty is latched once per counter period.
module pwm_dac
  import wavegen_pkg::*;
#(
  parameter int         CNT_W    = 8,
  parameter logic [7:0] GAIN_RST = GAIN_UNITY
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en_i,
  input  logic [SAMPLE_W-1:0] sample_i,
  input  logic [7:0]          gain_i,
  input  logic                gain_we_i,
  output logic                pwm_o,
  output logic                period_start_o,
  output logic [CNT_W-1:0]    duty_o,
  output logic                active_o,
  output logic [1:0]          state_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  pwm_state_t          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    duty_q;
  logic [CNT_W-1:0]    duty_next;
  logic [7:0]          gain_q, gain_sh_q, gain_sh_d;
  logic [SAMPLE_W-1:0] sat_sample;
  logic                pwm_q, start_q, active_q;
  logic                capture;
  logic                wrap;

  assign wrap = (cnt_q == CNT_MAX);

  // The scaler sees the gain that enters the shadow on this edge, so a write
  // landing on a capture edge misses it and takes effect one period later.
  assign gain_sh_d = capture ? gain_q : gain_sh_q;

  gain_sat u_gain_sat (
    .sample (sample_i),
    .gain   (gain_sh_d),
    .scaled (sat_sample)
  );

  assign duty_next = CNT_W'(sat_sample) << (CNT_W - 8);

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_i) begin
          capture = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!en_i)     state_d = DRAIN;
        else if (wrap) capture = 1'b1;
      end
      DRAIN: begin
        if (en_i) begin
          state_d = RUN;
          capture = wrap;
        end else if (wrap) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      duty_q    <= '0;
      gain_q    <= GAIN_RST;
      gain_sh_q <= GAIN_RST;
      pwm_q     <= 1'b0;
      start_q   <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= (state_q == IDLE) ? '0 : cnt_q + CNT_W'(1);
      gain_sh_q <= gain_sh_d;
      start_q   <= capture;
      pwm_q     <= (state_q != IDLE) && (cnt_q < duty_q);
      active_q  <= (state_d != IDLE);
      if (gain_we_i) gain_q <= gain_i;
      if (capture)   duty_q <= duty_next;
    end
  end

  assign pwm_o          = pwm_q;
  assign period_start_o = start_q;
  assign duty_o         = duty_q;
  assign active_o       = active_q;
  assign state_o        = state_q;

endmodule
